// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC register, imem request handshake, and a registered
// instruction/PC/format output for the immediate generator, with stall and redirect.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [2:0]  inst_type,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    TYPE_B   = 3'b000,
    TYPE_I   = 3'b001,
    TYPE_S   = 3'b010,
    TYPE_U   = 3'b011,
    TYPE_J   = 3'b100,
    TYPE_R   = 3'b101,
    TYPE_ILL = 3'b111
  } itype_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instruction_q, instruction_d;
  itype_t      inst_type_q, inst_type_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_out_q, valid_out_d;

  // Redirect targets are word aligned; the low bits are dropped on purpose.
  logic [1:0] unused_redirect_lsbs;
  assign unused_redirect_lsbs = redirect_pc[1:0];

  function automatic itype_t decode_type(input logic [6:0] opcode);
    itype_t t;
    case (opcode)
      7'b1100011:                                  t = TYPE_B;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: t = TYPE_I;
      7'b0100011:                                  t = TYPE_S;
      7'b0110111, 7'b0010111:                      t = TYPE_U;
      7'b1101111:                                  t = TYPE_J;
      7'b0110011:                                  t = TYPE_R;
      default:                                     t = TYPE_ILL;
    endcase
    return t;
  endfunction

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instruction_d = instruction_q;
    inst_type_d   = inst_type_q;
    pc_out_d      = pc_out_q;
    valid_out_d   = valid_out_q;

    if (redirect) begin
      // Flush: the word returned this cycle belongs to the old path.
      state_d       = FETCH;
      pc_d          = {redirect_pc[31:2], 2'b00};
      instruction_d = NOP_INSTR;
      inst_type_d   = TYPE_I;
      valid_out_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = FETCH;
        HOLD: if (!stall) state_d = FETCH;
        FETCH: begin
          if (stall) begin
            state_d = HOLD;
          end else if (imem_valid) begin
            instruction_d = imem_rdata;
            inst_type_d   = decode_type(imem_rdata[6:0]);
            pc_out_d      = pc_q;
            valid_out_d   = 1'b1;
            pc_d          = pc_q + 32'd4;
          end else begin
            instruction_d = NOP_INSTR;
            inst_type_d   = TYPE_I;
            valid_out_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instruction_q <= NOP_INSTR;
      inst_type_q   <= TYPE_I;
      pc_out_q      <= RESET_PC;
      valid_out_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instruction_q <= instruction_d;
      inst_type_q   <= inst_type_d;
      pc_out_q      <= pc_out_d;
      valid_out_q   <= valid_out_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instruction = instruction_q;
  assign inst_type   = inst_type_q;
  assign pc_out      = pc_out_q;
  assign valid_out   = valid_out_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage; each cycle compares the packed output
// vector {valid_out, inst_type, instruction, pc_out, imem_req, imem_addr}.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, imem_valid, stall, redirect;
  logic [31:0] imem_rdata, redirect_pc;
  logic        imem_req, valid_out;
  logic [31:0] imem_addr, instruction, pc_out;
  logic [2:0]  inst_type;
  logic [100:0] obs, exp_v;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  instr_fetch_stage #(
    .RESET_PC (32'h00000000),
    .NOP_INSTR(32'h00000013)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instruction(instruction),
    .inst_type  (inst_type),
    .pc_out     (pc_out),
    .valid_out  (valid_out)
  );

  assign obs = {valid_out, inst_type, instruction, pc_out, imem_req, imem_addr};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] d,
                       input logic s, input logic rd, input logic [31:0] rp);
    rst = r; imem_valid = v; imem_rdata = d; stall = s; redirect = rd; redirect_pc = rp;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_reset();
    // reset must override simultaneous redirect/stall/valid
    drive(1'b1, 1'b1, 32'h00000033, 1'b1, 1'b1, 32'h00000500);
    tick();
    exp_v = {1'b0, 3'b001, 32'h00000013, 32'h00000000, 1'b0, 32'h00000000};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_state got %h expected %h", obs, exp_v);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    exp_v = {1'b0, 3'b001, 32'h00000013, 32'h00000000, 1'b1, 32'h00000000};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL idle_to_fetch got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_first_fetch();
    drive(1'b0, 1'b1, 32'hFFF00013, 1'b0, 1'b0, 32'h0);
    tick();
    exp_v = {1'b1, 3'b001, 32'hFFF00013, 32'h00000000, 1'b1, 32'h00000004};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL first_fetch got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4] = '{32'h00408023, 32'hFE0006E3, 32'h00001037, 32'h0040006F};
    logic [2:0]  types [4] = '{3'b010, 3'b000, 3'b011, 3'b100};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, words[i], 1'b0, 1'b0, 32'h0);
      tick();
      exp_v = {1'b1, types[i], words[i], 32'(4 * i), 1'b1, 32'(4 * i + 4)};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL back_to_back[%0d] got %h expected %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_miss();
    drive(1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    tick();
    exp_v = {1'b0, 3'b001, 32'h00000013, 32'h0000000C, 1'b1, 32'h00000010};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL fetch_miss got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_stall();
    drive(1'b0, 1'b1, 32'h00000033, 1'b0, 1'b0, 32'h0);
    tick();
    exp_v = {1'b1, 3'b101, 32'h00000033, 32'h00000010, 1'b1, 32'h00000014};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL rtype_fetch got %h expected %h", obs, exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'h0000007F, 1'b1, 1'b0, 32'h0);
      tick();
      exp_v = {1'b1, 3'b101, 32'h00000033, 32'h00000010, 1'b0, 32'h00000014};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL stall_hold[%0d] got %h expected %h", i, obs, exp_v);
      end
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    exp_v = {1'b1, 3'b101, 32'h00000033, 32'h00000010, 1'b1, 32'h00000014};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL stall_release got %h expected %h", obs, exp_v);
    end
    drive(1'b0, 1'b1, 32'h0000007F, 1'b0, 1'b0, 32'h0);
    tick();
    exp_v = {1'b1, 3'b111, 32'h0000007F, 32'h00000014, 1'b1, 32'h00000018};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL illegal_after_hold got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_redirect();
    drive(1'b0, 1'b1, 32'h00000033, 1'b1, 1'b1, 32'h00000102);
    tick();
    exp_v = {1'b0, 3'b001, 32'h00000013, 32'h00000014, 1'b1, 32'h00000100};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL redirect_over_stall got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_reset_midfetch_wrap();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    exp_v = {1'b0, 3'b001, 32'h00000013, 32'h00000014, 1'b1, 32'h00000100};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL waiting_fetch got %h expected %h", obs, exp_v);
    end
    drive(1'b1, 1'b1, 32'h00000033, 1'b0, 1'b0, 32'h0);
    tick();
    exp_v = {1'b0, 3'b001, 32'h00000013, 32'h00000000, 1'b0, 32'h00000000};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_midfetch got %h expected %h", obs, exp_v);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFE);
    tick();
    exp_v = {1'b0, 3'b001, 32'h00000013, 32'h00000000, 1'b1, 32'hFFFFFFFC};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL redirect_align got %h expected %h", obs, exp_v);
    end
    drive(1'b0, 1'b1, 32'h00000517, 1'b0, 1'b0, 32'h0);
    tick();
    exp_v = {1'b1, 3'b011, 32'h00000517, 32'hFFFFFFFC, 1'b1, 32'h00000000};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL pc_wrap got %h expected %h", obs, exp_v);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_miss();
    test_stall();
    test_redirect();
    test_reset_midfetch_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
